// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, fetch FSM states, opcodes and ALU encodings.
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned JIDX_W   = 26;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // Main-decoder ALU op and ALU-control function encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump over branch over sequential pc+4.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]   pc,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_offset,
  input  logic              jump_signal,
  output logic [XLEN-1:0]   next_pc_c
);

  logic [XLEN-1:0] pc4;

  always_comb begin
    pc4       = pc + XLEN'(4);
    next_pc_c = pc4;
    if (jump_signal) begin
      next_pc_c = {pc4[XLEN-1:XLEN-4], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc_c = pc4 + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Two-state fetch unit: request a word, hold it until downstream accepts, then advance the PC.
// Optional accepted-instruction counter enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ready,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_offset,
  input  logic                jump_signal,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instr_out,
  output logic [OPCODE_W-1:0] opcode_out,
`ifdef IFETCH_PERF_CNT_EN
  output logic [XLEN-1:0]     fetch_count,
`endif
  output logic [XLEN-1:0]     pc_out
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  fetch_state_e    state;
  logic [XLEN-1:0] next_pc_c;

  pc_next_calc u_pc_next_calc (
    .pc            (pc_out),
    .jump_index    (instr_out[JIDX_W-1:0]),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_signal   (jump_signal),
    .next_pc_c     (next_pc_c)
  );

  assign imem_addr  = pc_out;
  assign opcode_out = instr_out[XLEN-1:XLEN-OPCODE_W];

  // imem_req is registered, so it only rises on the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc_out      <= RESET_PC_ALIGNED;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ready) begin
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end else begin
            imem_req <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_out      <= next_pc_c;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Saturating count of instructions accepted downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
    end else if (state == HOLD && !stall && fetch_count != '1) begin
      fetch_count <= fetch_count + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: driver queues expected requests/accepts, monitor checks them.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump_signal;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [5:0]  opcode_out;
  logic [31:0] pc_out;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_q[$];
  logic [63:0] acc_q[$];

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_signal   (jump_signal),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .opcode_out    (opcode_out),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_count   (fetch_count),
`endif
    .pc_out        (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: memory handshakes and downstream accepts, sampled on the falling edge
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (imem_req && imem_ready) begin
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req actual=%h expected=none", imem_addr);
          end else begin
            chk("req_addr", imem_addr, addr_q.pop_front());
          end
        end
        if (instr_valid && !stall) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_accept actual=%h expected=none", pc_out);
          end else begin
            e = acc_q.pop_front();
            chk("acc_pc", pc_out, e[63:32]);
            chk("acc_instr", instr_out, e[31:0]);
            chk("acc_opcode", 32'(opcode_out), 32'(e[31:26]));
          end
        end
      end
    end
  end

  // Called at posedge+1; answers the pending request after lat extra cycles
  task automatic serve(input logic [31:0] addr, input logic [31:0] word, input int lat);
    int n = 0;
    addr_q.push_back(addr);
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL req_timeout actual=%0d expected<50", n);
    end
    repeat (lat) begin @(posedge clk); #1; end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Stall for a while with junk branch inputs, then accept with the given controls
  task automatic accept(input logic [31:0] pc, input logic [31:0] instr, input int stalls,
                        input logic br, input logic jmp, input logic [31:0] off);
    acc_q.push_back({pc, instr});
    branch_taken  = 1'b1;
    jump_signal   = 1'b1;
    branch_offset = 32'h1234_5678;
    imem_ready    = 1'b1;
    imem_rdata    = 32'hBAD0_BAD0;
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      chk("stall_pc", pc_out, pc);
      chk("stall_instr", instr_out, instr);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
    end
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    stall         = 1'b0;
    branch_taken  = br;
    jump_signal   = jmp;
    branch_offset = off;
    @(posedge clk); #1;
    stall         = 1'b1;
    branch_taken  = 1'b1;
    jump_signal   = 1'b1;
    branch_offset = 32'h1234_5678;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_prev;
    logic [31:0] seq_words [4];
    seq_words[0] = 32'h8C01_0004;
    seq_words[1] = 32'h2002_0001;
    seq_words[2] = 32'h0022_1820;
    seq_words[3] = 32'hAC03_0008;

    reset_n = 1'b0; stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    branch_taken = 1'b1; jump_signal = 1'b1; branch_offset = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    imem_ready = 1'b0; imem_rdata = 32'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("req_after_rst", 32'(imem_req), 32'd1);
    @(posedge clk); #1;

    // Back-to-back sequential fetches, one accept every 2 cycles
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      serve(32'(4 * i), seq_words[i], 0);
      accept(32'(4 * i), seq_words[i], 0, 1'b0, 1'b0, 32'h0);
      if (i > 0) chk("throughput_ns", 32'($time - t_prev), 32'd20);
      t_prev = $time;
    end

    serve(32'h0000_0010, 32'h1000_FFFE, 0);
    accept(32'h0000_0010, 32'h1000_FFFE, 0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    serve(32'h0000_000C, 32'h1022_0003, 0);
    accept(32'h0000_000C, 32'h1022_0003, 0, 1'b1, 1'b0, 32'h0FFF_FFFC);
    serve(32'h4000_0000, 32'h0800_0040, 0);
    accept(32'h4000_0000, 32'h0800_0040, 0, 1'b1, 1'b1, 32'h0000_0004);
    serve(32'h4000_0100, 32'h0140_2020, 0);
    accept(32'h4000_0100, 32'h0140_2020, 5, 1'b0, 1'b0, 32'h0);
    serve(32'h4000_0104, 32'h8C43_0010, 3);
    accept(32'h4000_0104, 32'h8C43_0010, 0, 1'b1, 1'b0, 32'h2FFF_FFBD);
    serve(32'hFFFF_FFFC, 32'hAC44_0000, 0);
    accept(32'hFFFF_FFFC, 32'hAC44_0000, 0, 1'b0, 1'b0, 32'h0);
    serve(32'h0000_0000, 32'h2005_0007, 0);
    accept(32'h0000_0000, 32'h2005_0007, 0, 1'b0, 1'b0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("count_11", fetch_count, 32'd11);
`endif

    // Stalled memory at 0x4, reset pulsed in the 4th wait cycle
    @(negedge clk);
    chk("wait_addr", imem_addr, 32'h0000_0004);
    chk("wait_req", 32'(imem_req), 32'd1);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      serve(32'(4 * i), 32'h2000_0000 | 32'(i), (i == 0) ? 2 : 0);
      accept(32'(4 * i), 32'h2000_0000 | 32'(i), 0, 1'b0, 1'b0, 32'h0);
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("count_10", fetch_count, 32'd10);
`endif
    @(negedge clk);
    chk("final_pc", pc_out, 32'h0000_0028);
    repeat (3) @(posedge clk);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("acc_q_empty", 32'(acc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
